// File: rtl/pipe_hazard_unit.sv
// Hazard/forwarding controller: in-flight scoreboard, load-use stall, redirect flush, EX forwarding, WB->ID bypass.
// Define HAZARD_STATS_EN to build the saturating stall/flush statistics counters.
module pipe_hazard_unit #(
  parameter int DEPTH        = 3,
  parameter int REG_AW       = 5,
  parameter int LOAD_STG     = 2,
  parameter int REDIRECT_STG = 1,
  parameter int SEL_W        = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              id_valid_i,
  input  logic [REG_AW-1:0] id_rs_i,
  input  logic [REG_AW-1:0] id_rt_i,
  input  logic              id_uses_rs_i,
  input  logic              id_uses_rt_i,
  input  logic [REG_AW-1:0] id_dst_i,
  input  logic              id_wreg_i,
  input  logic              id_load_i,
  input  logic              redirect_i,
  output logic              stall_f_o,
  output logic              stall_d_o,
  output logic              flush_d_o,
  output logic              bubble_e_o,
  output logic [DEPTH-1:0]  kill_o,
  output logic [SEL_W-1:0]  fwd_a_o,
  output logic [SEL_W-1:0]  fwd_b_o,
  output logic              rf_byp_a_o,
  output logic              rf_byp_b_o,
  output logic [31:0]       stall_cnt_o,
  output logic [31:0]       flush_cnt_o
);

  logic              redirectLive;
  logic              loadUse;
  logic              accept;

  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [DEPTH-1:0]  wreg_q, wreg_d;
  logic [DEPTH-1:0]  load_q, load_d;
  logic [REG_AW-1:0] dst_q [DEPTH];
  logic [REG_AW-1:0] dst_d [DEPTH];
  logic [REG_AW-1:0] rsE_q, rsE_d, rtE_q, rtE_d;
  logic              usesRsE_q, usesRsE_d, usesRtE_q, usesRtE_d;

  // Redirect is masked while in reset so every output reads 0 during reset.
  assign redirectLive = redirect_i & reset_i;

  always_comb begin
    loadUse = 1'b0;
    for (int k = 0; k < LOAD_STG - 1; k++) begin
      if (valid_q[k] && wreg_q[k] && load_q[k]) begin
        if (id_uses_rs_i && (id_rs_i != '0) && (dst_q[k] == id_rs_i)) loadUse = 1'b1;
        if (id_uses_rt_i && (id_rt_i != '0) && (dst_q[k] == id_rt_i)) loadUse = 1'b1;
      end
    end
    loadUse = loadUse & id_valid_i;
  end

  assign stall_f_o  = loadUse & ~redirectLive;
  assign stall_d_o  = loadUse & ~redirectLive;
  assign flush_d_o  = redirectLive;
  assign bubble_e_o = loadUse | redirectLive;

  always_comb begin
    kill_o = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (redirectLive && (k < REDIRECT_STG)) kill_o[k] = 1'b1;
    end
  end

  assign rf_byp_a_o = valid_q[DEPTH-1] & wreg_q[DEPTH-1] & id_uses_rs_i &
                      (id_rs_i != '0) & (dst_q[DEPTH-1] == id_rs_i);
  assign rf_byp_b_o = valid_q[DEPTH-1] & wreg_q[DEPTH-1] & id_uses_rt_i &
                      (id_rt_i != '0) & (dst_q[DEPTH-1] == id_rt_i);

  // Walk oldest to youngest so the youngest eligible producer overwrites the select.
  always_comb begin
    fwd_a_o = '0;
    fwd_b_o = '0;
    for (int k = DEPTH - 1; k >= 1; k--) begin
      if (valid_q[k] && wreg_q[k] && !(load_q[k] && (k < LOAD_STG))) begin
        if (usesRsE_q && (rsE_q != '0) && (dst_q[k] == rsE_q)) fwd_a_o = SEL_W'(k);
        if (usesRtE_q && (rtE_q != '0) && (dst_q[k] == rtE_q)) fwd_b_o = SEL_W'(k);
      end
    end
  end

  assign accept = id_valid_i & ~stall_d_o & ~redirectLive;

  always_comb begin
    valid_d[0] = accept;
    wreg_d[0]  = id_wreg_i;
    load_d[0]  = id_load_i;
    dst_d[0]   = id_dst_i;
    rsE_d      = id_rs_i;
    rtE_d      = id_rt_i;
    usesRsE_d  = accept & id_uses_rs_i;
    usesRtE_d  = accept & id_uses_rt_i;
    for (int k = 1; k < DEPTH; k++) begin
      valid_d[k] = valid_q[k-1] & ~kill_o[k-1];
      wreg_d[k]  = wreg_q[k-1];
      load_d[k]  = load_q[k-1];
      dst_d[k]   = dst_q[k-1];
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      valid_q   <= '0;
      wreg_q    <= '0;
      load_q    <= '0;
      rsE_q     <= '0;
      rtE_q     <= '0;
      usesRsE_q <= 1'b0;
      usesRtE_q <= 1'b0;
      for (int k = 0; k < DEPTH; k++) dst_q[k] <= '0;
    end else begin
      valid_q   <= valid_d;
      wreg_q    <= wreg_d;
      load_q    <= load_d;
      rsE_q     <= rsE_d;
      rtE_q     <= rtE_d;
      usesRsE_q <= usesRsE_d;
      usesRtE_q <= usesRtE_d;
      for (int k = 0; k < DEPTH; k++) dst_q[k] <= dst_d[k];
    end
  end

`ifdef HAZARD_STATS_EN
  logic [31:0] stallCnt_q, flushCnt_q;

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      stallCnt_q <= '0;
      flushCnt_q <= '0;
    end else begin
      if (stall_d_o && (stallCnt_q != 32'hFFFF_FFFF)) stallCnt_q <= stallCnt_q + 32'd1;
      if (redirectLive && (flushCnt_q != 32'hFFFF_FFFF)) flushCnt_q <= flushCnt_q + 32'd1;
    end
  end

  assign stall_cnt_o = stallCnt_q;
  assign flush_cnt_o = flushCnt_q;
`else
  assign stall_cnt_o = '0;
  assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Bench for pipe_hazard_unit: directed instruction sequences, an instruction-record pipeline model
// checked every cycle, plus hand-computed literal checks from the hazard scenarios.
module tb_pipe_hazard_unit;

  localparam int DEPTH        = 3;
  localparam int REG_AW       = 5;
  localparam int LOAD_STG     = 2;
  localparam int REDIRECT_STG = 1;
  localparam int SEL_W        = $clog2(DEPTH);
`ifdef HAZARD_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  typedef struct packed {
    logic              v;
    logic [REG_AW-1:0] dst;
    logic              wr;
    logic              ld;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic              ur;
    logic              ut;
  } instT;

  logic              clk = 1'b0;
  logic              resetN;
  logic              idValid;
  logic [REG_AW-1:0] idRs, idRt, idDst;
  logic              idUsesRs, idUsesRt, idWreg, idLoad;
  logic              redirect;
  logic              stallF, stallD, flushD, bubbleE;
  logic [DEPTH-1:0]  kill;
  logic [SEL_W-1:0]  fwdA, fwdB;
  logic              rfBypA, rfBypB;
  logic [31:0]       stallCnt, flushCnt;

  int nChecks = 0;
  int nErrors = 0;

  instT        pipeM [DEPTH];
  logic [31:0] stallCntM, flushCntM;

  pipe_hazard_unit #(
    .DEPTH(DEPTH), .REG_AW(REG_AW), .LOAD_STG(LOAD_STG), .REDIRECT_STG(REDIRECT_STG)
  ) dut (
    .clk_i(clk), .reset_i(resetN),
    .id_valid_i(idValid), .id_rs_i(idRs), .id_rt_i(idRt),
    .id_uses_rs_i(idUsesRs), .id_uses_rt_i(idUsesRt),
    .id_dst_i(idDst), .id_wreg_i(idWreg), .id_load_i(idLoad),
    .redirect_i(redirect),
    .stall_f_o(stallF), .stall_d_o(stallD), .flush_d_o(flushD), .bubble_e_o(bubbleE),
    .kill_o(kill), .fwd_a_o(fwdA), .fwd_b_o(fwdB),
    .rf_byp_a_o(rfBypA), .rf_byp_b_o(rfBypB),
    .stall_cnt_o(stallCnt), .flush_cnt_o(flushCnt)
  );

  always #5 clk = ~clk;

  // A stage produces register r if it holds a valid writer of r and r is not $0.
  function automatic logic produces(int k, logic [REG_AW-1:0] r);
    return pipeM[k].v && pipeM[k].wr && (pipeM[k].dst == r) && (r != '0);
  endfunction

  function automatic logic modelRedirect();
    return redirect && resetN;
  endfunction

  function automatic logic modelLoadUse();
    logic hit = 1'b0;
    if (!idValid) return 1'b0;
    for (int k = 0; k <= LOAD_STG - 2; k++) begin
      if (pipeM[k].ld && ((idUsesRs && produces(k, idRs)) || (idUsesRt && produces(k, idRt))))
        hit = 1'b1;
    end
    return hit;
  endfunction

  function automatic logic [SEL_W-1:0] modelFwd(logic [REG_AW-1:0] r, logic used);
    if (!pipeM[0].v || !used) return '0;
    for (int k = 1; k < DEPTH; k++) begin
      if (produces(k, r) && !(pipeM[k].ld && k < LOAD_STG)) return SEL_W'(k);
    end
    return '0;
  endfunction

  function automatic logic [DEPTH-1:0] modelKill();
    logic [DEPTH-1:0] m = '0;
    for (int k = 0; k < DEPTH; k++) if (modelRedirect() && k < REDIRECT_STG) m[k] = 1'b1;
    return m;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Model advance: records move one stage per edge, killed stages leave as bubbles.
  always @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int k = 0; k < DEPTH; k++) pipeM[k] <= '0;
      stallCntM <= '0;
      flushCntM <= '0;
    end else begin : advance
      instT sh;
      instT nw;
      logic st;
      st = modelLoadUse() && !modelRedirect();
      if (st && stallCntM != 32'hFFFF_FFFF) stallCntM <= stallCntM + 1;
      if (modelRedirect() && flushCntM != 32'hFFFF_FFFF) flushCntM <= flushCntM + 1;
      for (int k = 1; k < DEPTH; k++) begin
        sh = pipeM[k-1];
        if (modelRedirect() && (k - 1) < REDIRECT_STG) sh.v = 1'b0;
        pipeM[k] <= sh;
      end
      nw = '0;
      if (idValid && !st && !modelRedirect()) begin
        nw.v = 1'b1; nw.dst = idDst; nw.wr = idWreg; nw.ld = idLoad;
        nw.rs = idRs; nw.rt = idRt; nw.ur = idUsesRs; nw.ut = idUsesRt;
      end
      pipeM[0] <= nw;
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin : compare
    logic lu, rd;
    lu = modelLoadUse();
    rd = modelRedirect();
    checkOutput("stall_f", 32'(stallF), 32'(lu && !rd));
    checkOutput("stall_d", 32'(stallD), 32'(lu && !rd));
    checkOutput("flush_d", 32'(flushD), 32'(rd));
    checkOutput("bubble_e", 32'(bubbleE), 32'(lu || rd));
    checkOutput("kill", 32'(kill), 32'(modelKill()));
    checkOutput("fwd_a", 32'(fwdA), 32'(modelFwd(pipeM[0].rs, pipeM[0].ur)));
    checkOutput("fwd_b", 32'(fwdB), 32'(modelFwd(pipeM[0].rt, pipeM[0].ut)));
    checkOutput("rf_byp_a", 32'(rfBypA), 32'(idUsesRs && produces(DEPTH-1, idRs)));
    checkOutput("rf_byp_b", 32'(rfBypB), 32'(idUsesRt && produces(DEPTH-1, idRt)));
    checkOutput("stall_cnt", stallCnt, STATS ? stallCntM : 32'd0);
    checkOutput("flush_cnt", flushCnt, STATS ? flushCntM : 32'd0);
  end

  // Drive one Decode slot for the next clock edge.
  task automatic applyStimulus(input logic v, input logic [REG_AW-1:0] rs, input logic [REG_AW-1:0] rt,
                               input logic ur, input logic ut, input logic [REG_AW-1:0] dst,
                               input logic wr, input logic ld, input logic rd);
    @(posedge clk);
    #1;
    idValid = v; idRs = rs; idRt = rt; idUsesRs = ur; idUsesRt = ut;
    idDst = dst; idWreg = wr; idLoad = ld; redirect = rd;
  endtask

  task automatic nop();
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 1; i++) nop();
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, ".stall_d"}, 32'(stallD), 32'd0);
    checkOutput({tag, ".stall_f"}, 32'(stallF), 32'd0);
    checkOutput({tag, ".flush_d"}, 32'(flushD), 32'd0);
    checkOutput({tag, ".bubble_e"}, 32'(bubbleE), 32'd0);
    checkOutput({tag, ".kill"}, 32'(kill), 32'd0);
    checkOutput({tag, ".fwd"}, 32'({fwdA, fwdB}), 32'd0);
    checkOutput({tag, ".byp"}, 32'({rfBypA, rfBypB}), 32'd0);
    checkOutput({tag, ".cnt"}, stallCnt | flushCnt, 32'd0);
  endtask

  // lw $8 followed by add $9,$8,$8: one stall cycle, then the add is accepted.
  task automatic loadUsePair();
    applyStimulus(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 5'd8, 5'd8, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 5'd8, 5'd8, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
    nop();
  endtask

  initial begin
    resetN = 1'b0;
    idValid = 1'b1; idRs = 5'd3; idRt = 5'd4; idUsesRs = 1'b1; idUsesRt = 1'b1;
    idDst = 5'd5; idWreg = 1'b1; idLoad = 1'b1; redirect = 1'b1;
    #12;
    $display("[TB] reset state");
    checkAllZero("reset");
    @(posedge clk); #1;
    resetN = 1'b1;
    nop();
    drain();

    $display("[TB] load-use");
    applyStimulus(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0);
    #1 checkOutput("lu.no_stall_lw", 32'(stallD), 32'd0);
    applyStimulus(1'b1, 5'd8, 5'd8, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
    #1 checkOutput("lu.stall_d", 32'(stallD), 32'd1);
    checkOutput("lu.bubble_e", 32'(bubbleE), 32'd1);
    applyStimulus(1'b1, 5'd8, 5'd8, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
    #1 checkOutput("lu.stall_released", 32'(stallD), 32'd0);
    nop();
    #1 checkOutput("lu.fwd_a", 32'(fwdA), 32'd2);
    checkOutput("lu.fwd_b", 32'(fwdB), 32'd2);
    drain();

    $display("[TB] alu chain");
    applyStimulus(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 5'd3, 5'd3, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0);
    #1 checkOutput("alu.sub_no_stall", 32'(stallD), 32'd0);
    applyStimulus(1'b1, 5'd3, 5'd4, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
    #1 checkOutput("alu.sub_fwd", 32'({fwdA, fwdB}), 32'({2'd1, 2'd1}));
    nop();
    #1 checkOutput("alu.or_fwd_a", 32'(fwdA), 32'd2);
    checkOutput("alu.or_fwd_b", 32'(fwdB), 32'd1);
    drain();

    $display("[TB] priority and zero register");
    applyStimulus(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 5'd7, 5'd7, 1'b1, 1'b1, 5'd10, 1'b1, 1'b0, 1'b0);
    nop();
    #1 checkOutput("prio.fwd", 32'({fwdA, fwdB}), 32'({2'd1, 2'd1}));
    drain();
    applyStimulus(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd11, 1'b1, 1'b0, 1'b0);
    #1 checkOutput("zero.no_stall", 32'(stallD), 32'd0);
    nop();
    #1 checkOutput("zero.fwd", 32'({fwdA, fwdB}), 32'd0);
    drain();

    $display("[TB] redirect during load-use stall");
    applyStimulus(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 5'd8, 5'd8, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b1);
    #1 checkOutput("redir.stall_d", 32'(stallD), 32'd0);
    checkOutput("redir.flush_d", 32'(flushD), 32'd1);
    checkOutput("redir.bubble_e", 32'(bubbleE), 32'd1);
    checkOutput("redir.kill", 32'(kill), 32'b001);
    applyStimulus(1'b1, 5'd8, 5'd9, 1'b1, 1'b1, 5'd11, 1'b1, 1'b0, 1'b0);
    #1 checkOutput("redir.after_no_stall", 32'(stallD), 32'd0);
    nop();
    #1 checkOutput("redir.killed_lw_no_fwd", 32'(fwdA), 32'd0);
    checkOutput("redir.blocked_add_no_fwd", 32'(fwdB), 32'd0);
    drain();

    $display("[TB] writeback bypass");
    applyStimulus(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd12, 1'b1, 1'b0, 1'b0);
    nop();
    nop();
    applyStimulus(1'b1, 5'd12, 5'd12, 1'b1, 1'b0, 5'd13, 1'b1, 1'b0, 1'b0);
    #1 checkOutput("byp.a12", 32'(rfBypA), 32'd1);
    checkOutput("byp.b_unused", 32'(rfBypB), 32'd0);
    drain();
    applyStimulus(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
    nop();
    nop();
    applyStimulus(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd13, 1'b1, 1'b0, 1'b0);
    #1 checkOutput("byp.zero", 32'({rfBypA, rfBypB}), 32'd0);
    drain();

    $display("[TB] reset mid-stall and statistics");
    applyStimulus(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 5'd8, 5'd8, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
    #1 checkOutput("rst.stall_before", 32'(stallD), 32'd1);
    resetN = 1'b0;
    #1 checkAllZero("rst.mid_stall");
    @(posedge clk); #1;
    resetN = 1'b1;
    nop();
    for (int i = 0; i < 3; i++) loadUsePair();
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    nop();
    #1 checkOutput("stats.stall_cnt", stallCnt, STATS ? 32'd3 : 32'd0);
    checkOutput("stats.flush_cnt", flushCnt, STATS ? 32'd2 : 32'd0);
    drain();

    @(posedge clk); #1;
    $display("== %0d vectors applied, %0d miscompares ==", nChecks, nErrors);
    $finish;
  end

endmodule
